mem_port_arbiter: RTL and testbench

- Parametrised N-channel successor to the fixed cart/USB request muxing.
- Arbitrates read/write requests from NUM_CH requesters onto one shared memory-buffer port:
  - Channel 0: cart, 16-bit.
  - Channel 1: USB, 32-bit.
  - Further channels: e.g. a debug port.
- Provides byte enables, a registered command stage, and multiple in-order outstanding reads.
- Read data is routed back to the originating channel through a tag FIFO.

---
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// N-channel read/write arbiter onto one shared memory port.
// One registered command stage; in-order read tags route returns to channels.
module mem_port_arbiter #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned ADDR_W   = 26,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_OUT  = 4,
  parameter int unsigned ARB_MODE = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            ch_rd,
  input  logic [NUM_CH-1:0]            ch_wr,
  input  logic [NUM_CH*ADDR_W-1:0]     ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]     ch_wdata,
  input  logic [NUM_CH*DATA_W/8-1:0]   ch_be,
  output logic [NUM_CH-1:0]            ch_ready,
  output logic [NUM_CH-1:0]            ch_rd_valid,
  output logic [DATA_W-1:0]            ch_rd_data,
  output logic                         mem_rd,
  output logic                         mem_wr,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic [DATA_W/8-1:0]          mem_be,
  input  logic                         mem_ready,
  input  logic                         mem_rd_valid,
  input  logic [DATA_W-1:0]            mem_rd_data,
  output logic                         rd_err
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PTR_W = $clog2(MAX_OUT);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_a  [NUM_CH];
  logic [DATA_W-1:0] wdata_a [NUM_CH];
  logic [BE_W-1:0]   be_a    [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign addr_a[i]  = ch_addr[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = ch_wdata[i*DATA_W +: DATA_W];
    assign be_a[i]    = ch_be[i*BE_W +: BE_W];
  end

  logic [CH_W-1:0]  cmd_ch;
  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  tag_mem [MAX_OUT];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic              cmd_valid;
  logic              load_en;
  logic              rd_room;
  logic [NUM_CH-1:0] elig;
  logic              gnt_found;
  logic [CH_W-1:0]   gnt_ch;
  logic              gnt_rd;
  logic              grant;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              spurious;
  logic [CH_W-1:0]   head_ch;
  logic [CH_W-1:0]   rr_next;

  // A read in the command register already holds a tag slot.
  always_comb begin
    cmd_valid = mem_rd | mem_wr;
    load_en   = !cmd_valid || mem_ready;
    rd_room   = (count + CNT_W'(mem_rd)) < CNT_W'(MAX_OUT);
    for (int i = 0; i < int'(NUM_CH); i++) begin
      elig[i] = ch_rd[i] ? rd_room : ch_wr[i];
    end
  end

  // Round-robin search from rr_ptr, or fixed lowest-index priority.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_ch    = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      idx = (ARB_MODE == 0) ? ((int'(rr_ptr) + k) % int'(NUM_CH)) : k;
      if (!gnt_found && elig[CH_W'(idx)]) begin
        gnt_found = 1'b1;
        gnt_ch    = CH_W'(idx);
      end
    end
  end

  always_comb begin
    grant    = gnt_found && load_en;
    gnt_rd   = ch_rd[gnt_ch];
    rr_next  = (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + CH_W'(1);
    ch_ready = '0;
    if (grant && rst_n) begin
      ch_ready[gnt_ch] = 1'b1;
    end
  end

  // Tag FIFO control; an empty FIFO forwards the tag being pushed.
  always_comb begin
    push       = mem_rd && mem_ready;
    fifo_empty = (count == '0);
    pop        = mem_rd_valid && (!fifo_empty || push);
    spurious   = mem_rd_valid && fifo_empty && !push;
    head_ch    = fifo_empty ? cmd_ch : tag_mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= cmd_ch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= '0;
      cmd_ch      <= '0;
      rr_ptr      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      ch_rd_valid <= '0;
      ch_rd_data  <= '0;
      rd_err      <= 1'b0;
    end else begin
      if (load_en) begin
        if (gnt_found) begin
          mem_rd    <= gnt_rd;
          mem_wr    <= !gnt_rd;
          mem_addr  <= addr_a[gnt_ch];
          mem_wdata <= wdata_a[gnt_ch];
          mem_be    <= be_a[gnt_ch];
          cmd_ch    <= gnt_ch;
          if (ARB_MODE == 0) begin
            rr_ptr <= rr_next;
          end
        end else begin
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
        end
      end

      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end

      ch_rd_valid <= '0;
      if (pop) begin
        ch_rd_valid[head_ch] <= 1'b1;
        ch_rd_data           <= mem_rd_data;
      end
      if (spurious) begin
        rd_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_mem_port_arbiter;

  localparam int unsigned NUM_CH  = 2;
  localparam int unsigned ADDR_W  = 26;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BE_W    = 4;
  localparam int unsigned MAX_OUT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_CH-1:0]        ch_rd, ch_wr;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*DATA_W-1:0] ch_wdata;
  logic [NUM_CH*BE_W-1:0]   ch_be;
  logic                     mem_ready, mem_rd_valid;
  logic [DATA_W-1:0]        mem_rd_data;

  logic [NUM_CH-1:0] ch_ready, ch_rd_valid;
  logic [DATA_W-1:0] ch_rd_data, mem_wdata;
  logic              mem_rd, mem_wr, rd_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [BE_W-1:0]   mem_be;

  logic [NUM_CH-1:0] fx_ch_ready, fx_ch_rd_valid;
  logic [DATA_W-1:0] fx_ch_rd_data, fx_mem_wdata;
  logic              fx_mem_rd, fx_mem_wr, fx_rd_err;
  logic [ADDR_W-1:0] fx_mem_addr;
  logic [BE_W-1:0]   fx_mem_be;

  mem_port_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                     .MAX_OUT(MAX_OUT), .ARB_MODE(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .ch_rd(ch_rd), .ch_wr(ch_wr), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_be(ch_be), .ch_ready(ch_ready),
    .ch_rd_valid(ch_rd_valid), .ch_rd_data(ch_rd_data), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .rd_err(rd_err)
  );

  mem_port_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                     .MAX_OUT(MAX_OUT), .ARB_MODE(1)) u_fix (
    .clk(clk), .rst_n(rst_n), .ch_rd(ch_rd), .ch_wr(ch_wr), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_be(ch_be), .ch_ready(fx_ch_ready),
    .ch_rd_valid(fx_ch_rd_valid), .ch_rd_data(fx_ch_rd_data), .mem_rd(fx_mem_rd),
    .mem_wr(fx_mem_wr), .mem_addr(fx_mem_addr), .mem_wdata(fx_mem_wdata),
    .mem_be(fx_mem_be), .mem_ready(mem_ready), .mem_rd_valid(mem_rd_valid),
    .mem_rd_data(mem_rd_data), .rd_err(fx_rd_err)
  );

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic set_ch(input int c, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    ch_addr[c*ADDR_W +: ADDR_W]  = a;
    ch_wdata[c*DATA_W +: DATA_W] = d;
    ch_be[c*BE_W +: BE_W]        = be;
  endtask

  task automatic idle();
    ch_rd = '0; ch_wr = '0; mem_ready = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0] rd;
    logic [1:0] wr;
    logic       mr;
    logic [1:0] exp_ready;
    logic       exp_mrd;
    logic       exp_mwr;
  } vec_t;

  vec_t tbl [19];

  // Reference model state for the randomized phase
  bit                req_rd [NUM_CH];
  bit                req_wr [NUM_CH];
  logic [ADDR_W-1:0] r_addr [NUM_CH];
  logic [DATA_W-1:0] r_data [NUM_CH];
  logic [BE_W-1:0]   r_be   [NUM_CH];
  bit                m_cmd_v, m_cmd_rd;
  int                m_cmd_ch;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic [BE_W-1:0]   m_be;
  int                rr, inflight;
  int                tagq [$];
  logic [DATA_W-1:0] memq [$];
  logic [1:0]        e_rv;
  logic [DATA_W-1:0] e_rd;
  bit                e_err;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    ch_addr = '0; ch_wdata = '0; ch_be = '0;
    // Outputs stay low during reset even with requests present
    ch_wr = 2'b11; mem_ready = 1'b1;
    @(negedge clk);
    chk("rst_ready", ch_ready, 2'b00);
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_mem_wr", mem_wr, 1'b0);
    chk("rst_rd_err", rd_err, 1'b0);
    chk("rst_rd_valid", ch_rd_valid, 2'b00);
    do_reset();

    // rd, wr, mem_ready, ch_ready, current mem_rd, current mem_wr
    tbl[0]  = '{2'b00, 2'b11, 1'b1, 2'b01, 1'b0, 1'b0};
    tbl[1]  = '{2'b00, 2'b11, 1'b1, 2'b10, 1'b0, 1'b1};
    tbl[2]  = '{2'b00, 2'b11, 1'b1, 2'b01, 1'b0, 1'b1};
    tbl[3]  = '{2'b00, 2'b11, 1'b1, 2'b10, 1'b0, 1'b1};
    tbl[4]  = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1};
    tbl[5]  = '{2'b00, 2'b10, 1'b1, 2'b10, 1'b0, 1'b0};
    tbl[6]  = '{2'b00, 2'b11, 1'b0, 2'b00, 1'b0, 1'b1};
    tbl[7]  = '{2'b00, 2'b11, 1'b1, 2'b01, 1'b0, 1'b1};
    tbl[8]  = '{2'b01, 2'b00, 1'b1, 2'b01, 1'b0, 1'b1};
    tbl[9]  = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0};
    tbl[10] = '{2'b11, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0};
    tbl[11] = '{2'b01, 2'b10, 1'b1, 2'b01, 1'b1, 1'b0};
    tbl[12] = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0};
    tbl[13] = '{2'b11, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0};
    tbl[14] = '{2'b11, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0};
    tbl[15] = '{2'b11, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0};
    tbl[16] = '{2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0};
    tbl[17] = '{2'b00, 2'b11, 1'b1, 2'b01, 1'b0, 1'b0};
    tbl[18] = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1};
    for (int i = 0; i < 19; i++) begin
      ch_rd = tbl[i].rd; ch_wr = tbl[i].wr; mem_ready = tbl[i].mr;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), ch_ready, tbl[i].exp_ready);
      chk($sformatf("tbl%0d_mem_rd", i), mem_rd, tbl[i].exp_mrd);
      chk($sformatf("tbl%0d_mem_wr", i), mem_wr, tbl[i].exp_mwr);
      cyc();
    end

    // Single read with a delayed return
    do_reset();
    set_ch(0, 26'h0000100, 32'h0, 4'hF);
    ch_rd = 2'b01; mem_ready = 1'b1;
    @(negedge clk);
    chk("rd1_ready", ch_ready, 2'b01);
    chk("rd1_mem_rd_c0", mem_rd, 1'b0);
    cyc(); ch_rd = 2'b00;
    @(negedge clk);
    chk("rd1_mem_rd_c1", mem_rd, 1'b1);
    chk("rd1_addr", mem_addr, 26'h0000100);
    chk("rd1_no_ready", ch_ready, 2'b00);
    cyc(); cyc();
    mem_rd_valid = 1'b1; mem_rd_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("rd1_early_valid", ch_rd_valid, 2'b00);
    cyc(); mem_rd_valid = 1'b0; mem_rd_data = '0;
    @(negedge clk);
    chk("rd1_valid", ch_rd_valid, 2'b01);
    chk("rd1_data", ch_rd_data, 32'hDEADBEEF);
    chk("rd1_err", rd_err, 1'b0);
    cyc();
    @(negedge clk);
    chk("rd1_valid_pulse", ch_rd_valid, 2'b00);

    // Backpressure on a pending write
    do_reset();
    set_ch(1, 26'h000002A, 32'h12345678, 4'b0011);
    set_ch(0, 26'h000003B, 32'hCAFEF00D, 4'b1111);
    ch_wr = 2'b10; mem_ready = 1'b0;
    @(negedge clk);
    chk("bp_load_ready", ch_ready, 2'b10);
    cyc(); ch_wr = 2'b01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_wr", i), mem_wr, 1'b1);
      chk($sformatf("bp%0d_wdata", i), mem_wdata, 32'h12345678);
      chk($sformatf("bp%0d_be", i), mem_be, 4'b0011);
      chk($sformatf("bp%0d_addr", i), mem_addr, 26'h000002A);
      chk($sformatf("bp%0d_ready", i), ch_ready, 2'b00);
      cyc();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", ch_ready, 2'b01);
    chk("bp_release_wdata", mem_wdata, 32'h12345678);
    cyc(); ch_wr = 2'b00;
    @(negedge clk);
    chk("bp_next_wr", mem_wr, 1'b1);
    chk("bp_next_wdata", mem_wdata, 32'hCAFEF00D);
    chk("bp_next_be", mem_be, 4'hF);
    cyc();
    @(negedge clk);
    chk("bp_drain", mem_wr, 1'b0);

    // Round-robin against fixed priority under continuous writes
    do_reset();
    ch_wr = 2'b11; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("rr%0d", i), ch_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("fix%0d", i), fx_ch_ready, 2'b01);
      cyc();
    end

    // Fill the tag FIFO, write still granted, returns routed in order
    do_reset();
    ch_rd = 2'b11; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("full_gnt%0d", i), ch_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      cyc();
    end
    ch_rd = 2'b01; ch_wr = 2'b10;
    @(negedge clk);
    chk("full_wr_granted", ch_ready, 2'b10);
    cyc(); ch_wr = 2'b00;
    @(negedge clk);
    chk("full_wr_issued", mem_wr, 1'b1);
    chk("full_rd_blocked0", ch_ready, 2'b00);
    cyc();
    @(negedge clk);
    chk("full_rd_blocked1", ch_ready, 2'b00);
    cyc(); ch_rd = 2'b00;
    for (int i = 0; i < 4; i++) begin
      mem_rd_valid = 1'b1; mem_rd_data = 32'hA0 + 32'(i);
      cyc();
      chk($sformatf("ret%0d_valid", i), ch_rd_valid, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("ret%0d_data", i), ch_rd_data, 32'hA0 + 32'(i));
    end
    mem_rd_valid = 1'b0;
    cyc();
    chk("ret_done", ch_rd_valid, 2'b00);
    chk("ret_no_err", rd_err, 1'b0);

    // Spurious return with nothing outstanding
    mem_rd_valid = 1'b1; mem_rd_data = 32'h5555AAAA;
    cyc(); mem_rd_valid = 1'b0;
    chk("spur_err", rd_err, 1'b1);
    chk("spur_no_valid", ch_rd_valid, 2'b00);
    repeat (3) cyc();
    chk("spur_sticky", rd_err, 1'b1);

    // Reset with two reads outstanding
    ch_rd = 2'b11; mem_ready = 1'b1;
    @(negedge clk); chk("mid_gnt0", ch_ready, 2'b01); cyc();
    @(negedge clk); chk("mid_gnt1", ch_ready, 2'b10); cyc();
    ch_rd = 2'b00; ch_wr = 2'b01;
    @(negedge clk); chk("mid_gnt2", ch_ready, 2'b01); cyc();
    ch_wr = 2'b11;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", ch_ready, 2'b00);
    chk("mid_rst_mem_rd", mem_rd, 1'b0);
    chk("mid_rst_mem_wr", mem_wr, 1'b0);
    chk("mid_rst_addr", mem_addr, '0);
    chk("mid_rst_wdata", mem_wdata, '0);
    chk("mid_rst_be", mem_be, '0);
    chk("mid_rst_rdata", ch_rd_data, '0);
    chk("mid_rst_err", rd_err, 1'b0);
    ch_wr = 2'b00;
    cyc(); rst_n = 1'b1;
    mem_rd_valid = 1'b1;
    cyc(); mem_rd_valid = 1'b0;
    chk("post_rst_empty_err", rd_err, 1'b1);
    chk("post_rst_no_valid", ch_rd_valid, 2'b00);
    ch_wr = 2'b11;
    @(negedge clk);
    chk("post_rst_first_gnt", ch_ready, 2'b01);
    cyc();

    // Randomized traffic against the reference model
    do_reset();
    m_cmd_v = 0; m_cmd_rd = 0; m_cmd_ch = 0; rr = 0; inflight = 0;
    e_rv = '0; e_rd = '0; e_err = 0;
    for (int c = 0; c < int'(NUM_CH); c++) begin req_rd[c] = 0; req_wr[c] = 0; end
    for (int n = 0; n < 800; n++) begin
      int g;
      int hc;
      logic [1:0] exp_ready;
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (!req_rd[c] && !req_wr[c] && $urandom_range(2) == 0) begin
          int k;
          k = int'($urandom_range(3));
          req_rd[c] = (k == 0 || k == 2);
          req_wr[c] = (k != 0);
          r_addr[c] = ADDR_W'($urandom);
          r_data[c] = $urandom;
          r_be[c]   = BE_W'($urandom);
        end
        ch_rd[c] = req_rd[c];
        ch_wr[c] = req_wr[c];
        set_ch(c, r_addr[c], r_data[c], r_be[c]);
      end
      mem_ready = ($urandom_range(3) != 0);
      if (memq.size() > 0 && $urandom_range(1) == 1) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = memq.pop_front();
      end else begin
        mem_rd_valid = 1'b0;
        mem_rd_data  = $urandom;
      end
      @(negedge clk);
      chk("rnd_rd_valid", ch_rd_valid, e_rv);
      if (e_rv != 2'b00) chk("rnd_rd_data", ch_rd_data, e_rd);
      chk("rnd_rd_err", rd_err, e_err);
      chk("rnd_mem_rd", mem_rd, m_cmd_v && m_cmd_rd);
      chk("rnd_mem_wr", mem_wr, m_cmd_v && !m_cmd_rd);
      if (m_cmd_v) begin
        chk("rnd_addr", mem_addr, m_addr);
        chk("rnd_wdata", mem_wdata, m_data);
        chk("rnd_be", mem_be, m_be);
      end
      g = -1;
      if (!m_cmd_v || mem_ready) begin
        for (int k = 0; k < int'(NUM_CH); k++) begin
          int c;
          bit el;
          c  = (rr + k) % int'(NUM_CH);
          el = req_rd[c] ? (inflight < int'(MAX_OUT)) : req_wr[c];
          if (el && g < 0) g = c;
        end
      end
      exp_ready = (g >= 0) ? 2'(1 << g) : 2'b00;
      chk("rnd_ready", ch_ready, exp_ready);
      if (m_cmd_v && mem_ready) begin
        if (m_cmd_rd) begin
          tagq.push_back(m_cmd_ch);
          memq.push_back($urandom);
        end
        m_cmd_v = 0;
      end
      e_rv = 2'b00;
      if (mem_rd_valid) begin
        if (tagq.size() > 0) begin
          hc = tagq.pop_front();
          e_rv = 2'(1 << hc);
          e_rd = mem_rd_data;
          inflight--;
        end else begin
          e_err = 1;
        end
      end
      if (g >= 0) begin
        m_cmd_v  = 1;
        m_cmd_rd = req_rd[g];
        m_cmd_ch = g;
        m_addr   = r_addr[g];
        m_data   = r_data[g];
        m_be     = r_be[g];
        if (req_rd[g]) begin
          req_rd[g] = 0;
          inflight++;
        end else begin
          req_wr[g] = 0;
        end
        rr = (g + 1) % int'(NUM_CH);
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
